// File: rtl/unscrambler2_if.sv
// Handshake and regfile bus between the unscramble controller and its host.
// The host side also supplies combinational regfile read data.
interface unscrambler2_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          start;
    logic [15:0]   seed;
    logic [AW:0]   len;
    logic [DW-1:0] rf_dout;
    logic [AW-1:0] rf_r_addr;
    logic [AW-1:0] rf_w_addr;
    logic [DW-1:0] rf_din;
    logic          rf_wr_en;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, seed, len, rf_dout,
        input  rf_r_addr, rf_w_addr, rf_din, rf_wr_en, busy, done, err
    );

    modport slave (
        input  start, seed, len, rf_dout,
        output rf_r_addr, rf_w_addr, rf_din, rf_wr_en, busy, done, err
    );
endinterface

// File: rtl/unscrambler2_controller.sv
// Undoes the scrambler's LFSR-driven swap shuffle of a register file by
// regenerating its swap indices onto a stack and replaying them in reverse.
module unscrambler2_controller #(
    parameter int DW    = 8,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    unscrambler2_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        GEN,
        READ,
        SWAP,
        WRITE,
        DONE
    } state_t;

    localparam logic [AW:0] MAX_LEN = (AW+1)'(DEPTH);
    localparam logic [AW:0] TWO     = (AW+1)'(2);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] k;
    logic [DW-1:0] temp;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_next;
    logic [AW:0]   len_q;
    logic          err_q;
    logic [AW-1:0] stack [DEPTH];
    logic [AW-1:0] jk;
    logic          last_gen;

    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign jk        = AW'(lfsr % {{(15-AW){1'b0}}, len_q});
    assign last_gen  = ({1'b0, k} == (len_q - TWO));
    assign bus.err   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;
        bus.rf_r_addr = '0;
        bus.rf_w_addr = '0;
        bus.rf_din    = '0;
        bus.rf_wr_en  = 1'b0;
        unique case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start && bus.len <= MAX_LEN) begin
                    state_next = (bus.len < TWO) ? DONE : GEN;
                end
            end
            GEN: begin
                if (last_gen) begin
                    state_next = READ;
                end
            end
            READ: begin
                bus.rf_r_addr = k;
                state_next    = SWAP;
            end
            SWAP: begin
                bus.rf_r_addr = stack[k];
                bus.rf_w_addr = k;
                bus.rf_din    = bus.rf_dout;
                bus.rf_wr_en  = 1'b1;
                state_next    = WRITE;
            end
            WRITE: begin
                bus.rf_w_addr = stack[k];
                bus.rf_din    = temp;
                bus.rf_wr_en  = 1'b1;
                state_next    = (k == '0) ? DONE : READ;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k     <= '0;
            temp  <= '0;
            lfsr  <= '0;
            len_q <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            err_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.len > MAX_LEN) begin
                            err_q <= 1'b1;
                        end else begin
                            len_q <= bus.len;
                            lfsr  <= (bus.seed == 16'h0000) ? 16'h0001 : bus.seed;
                            k     <= '0;
                        end
                    end
                end
                GEN: begin
                    stack[k] <= jk;
                    lfsr     <= lfsr_next;
                    // on the last index k already equals len-2, where replay starts
                    if (!last_gen) begin
                        k <= k + AW'(1);
                    end
                end
                READ: begin
                    temp <= bus.rf_dout;
                end
                WRITE: begin
                    if (k != '0) begin
                        k <= k - AW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_unscrambler2_controller.sv
// Bench for unscrambler2_controller: scrambles a regfile image with a
// reference shuffle, runs the restore and checks order, timing and writes.
module tb_unscrambler2_controller;
    logic       clk;
    logic       rst_n;
    logic       load;
    logic [7:0] rf   [16];
    logic [7:0] img  [16];
    logic [7:0] orig [16];
    int         wr_cnt;
    int         checks;
    int         errors;

    unscrambler2_if #(.DW(8), .AW(4)) u_if ();

    unscrambler2_controller #(.DW(8), .AW(4), .DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign u_if.rf_dout = rf[u_if.rf_r_addr];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) rf[i] <= img[i];
            wr_cnt <= 0;
        end else if (u_if.rf_wr_en) begin
            rf[u_if.rf_w_addr] <= u_if.rf_din;
            wr_cnt <= wr_cnt + 1;
        end
    end

    typedef struct {
        logic [15:0] seed;
        int          len;
        int          lat;
        int          nwr;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // forward scrambler: for i in 0..len-2 swap img[i] with img[lfsr % len]
    task automatic prep(input logic [15:0] sd, input int ln);
        logic [7:0]  base;
        logic [15:0] s;
        logic [7:0]  t;
        int          j;
        base = 8'($urandom);
        for (int i = 0; i < 16; i++) begin
            orig[i] = 8'(i * 17) + base;
            img[i]  = orig[i];
        end
        s = (sd == 16'h0000) ? 16'h0001 : sd;
        for (int i = 0; i < ln - 1; i++) begin
            j      = int'(s % 16'(ln));
            t      = img[i];
            img[i] = img[j];
            img[j] = t;
            s      = lfsr_step(s);
        end
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [15:0] sd,
                          input int ln, input int lat, input int nwr,
                          input bit inject);
        int cyc;
        bit seen;
        bit busy_low;
        prep(sd, ln);
        u_if.start = 1'b1;
        u_if.seed  = sd;
        u_if.len   = 5'(ln);
        cyc      = 0;
        seen     = 1'b0;
        busy_low = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            u_if.start = 1'b0;
            if (inject && cyc == 3) begin
                u_if.start = 1'b1;
                u_if.seed  = sd ^ 16'h1357;
                u_if.len   = 5'(ln - 3);
            end
            if (u_if.done) seen = 1'b1;
            else if (!u_if.busy) busy_low = 1'b1;
        end
        check({tag, "_latency"}, seen ? cyc : -1, lat);
        check({tag, "_busy_run"}, {31'b0, busy_low}, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {30'b0, u_if.done, u_if.busy}, 0);
        check({tag, "_writes"}, wr_cnt, nwr);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_rf%0d", tag, i), {24'b0, rf[i]}, {24'b0, orig[i]});
        end
    endtask

    initial begin
        int cnt0;
        int ln;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        load       = 1'b0;
        u_if.start = 1'b0;
        u_if.seed  = '0;
        u_if.len   = '0;
        tbl[0] = '{16'hACE1, 5, 17, 8};
        tbl[1] = '{16'h0000, 16, 61, 30};
        tbl[2] = '{16'h1234, 1, 1, 0};
        tbl[3] = '{16'h4321, 0, 1, 0};
        tbl[4] = '{16'hBEEF, 2, 5, 2};
        tbl[5] = '{16'h0F0F, 3, 9, 4};
        tbl[6] = '{16'hFFFF, 8, 29, 14};

        repeat (2) @(negedge clk);
        check("reset_outputs", {u_if.busy, u_if.done, u_if.err, u_if.rf_wr_en,
              u_if.rf_r_addr, u_if.rf_w_addr, u_if.rf_din}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[n]) begin
            run_op($sformatf("tbl%0d", n), tbl[n].seed, tbl[n].len,
                   tbl[n].lat, tbl[n].nwr, 1'b0);
        end

        // oversize length is rejected with a single err pulse
        cnt0 = wr_cnt;
        u_if.start = 1'b1;
        u_if.len   = 5'd17;
        u_if.seed  = 16'h2222;
        @(negedge clk);
        u_if.start = 1'b0;
        check("err_pulse", {29'b0, u_if.err, u_if.busy, u_if.done}, 32'h4);
        @(negedge clk);
        check("err_clear", {29'b0, u_if.err, u_if.busy, u_if.done}, 0);
        check("err_writes", wr_cnt, cnt0);

        run_op("restart_ignored", 16'h9ABC, 8, 29, 14, 1'b1);

        // reset lands in the WRITE cycle of the first swap pair
        prep(16'h5A5A, 8);
        u_if.start = 1'b1;
        u_if.seed  = 16'h5A5A;
        u_if.len   = 5'd8;
        @(negedge clk);
        u_if.start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_reset_write", {31'b0, u_if.rf_wr_en}, 1);
        cnt0  = wr_cnt;
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", {u_if.busy, u_if.done, u_if.err, u_if.rf_wr_en,
              u_if.rf_r_addr, u_if.rf_w_addr, u_if.rf_din}, 0);
        @(negedge clk);
        check("mid_reset_no_write", wr_cnt, cnt0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post_reset", 16'h7777, 8, 29, 14, 1'b0);

        for (int r = 0; r < 16; r++) begin
            ln = int'($urandom_range(0, 16));
            run_op($sformatf("rnd%0d", r), 16'($urandom), ln,
                   (ln < 2) ? 1 : 4 * (ln - 1) + 1,
                   (ln < 2) ? 0 : 2 * (ln - 1), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
